// File: rtl/coeff_pack_buffer_if.sv
// Bus between the coefficient feeder, the pack buffer and the downstream mux.
// Both the in_* and sel_* channels transfer on a rising edge where valid && ready.
// A producer must not make valid depend on ready, and must hold its data stable while waiting.
interface coeff_pack_buffer_if #(
  parameter int N = 4,
  parameter int S = 16
);
  localparam int SW = $clog2(S);

  logic [N-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [S*N-1:0] a;
  logic [SW-1:0]  sel;
  logic           sel_valid;
  logic           sel_ready;
  logic           done;
  logic           busy;
  logic           dbg_state;  // 0 = LOAD, 1 = SCAN

  modport master (
    output in_data, in_valid, sel_ready,
    input  in_ready, a, sel, sel_valid, done, busy, dbg_state
  );

  modport slave (
    input  in_data, in_valid, sel_ready,
    output in_ready, a, sel, sel_valid, done, busy, dbg_state
  );
endinterface

// File: rtl/coeff_pack_buffer.sv
// Collects S serial N-bit coefficients into a packed vector, then scans the
// mux select 0..S-1 with the vector held, one index per accepted handshake.
module coeff_pack_buffer #(
  parameter int N = 4,
  parameter int S = 16
) (
  input  logic               clk,
  input  logic               rst,
  coeff_pack_buffer_if.slave bus
);
  localparam int SW = $clog2(S);

  typedef enum logic {
    LOAD = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [SW-1:0]  wr_cnt_q;
  logic [SW-1:0]  sel_q;
  logic [S*N-1:0] a_q;
  logic           done_q;

  logic in_ready_int;
  logic sel_valid_int;
  logic in_fire;
  logic sel_fire;
  logic last_word;
  logic last_sel;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: if (in_fire && last_word) state_d = SCAN;
      SCAN: if (sel_fire && last_sel) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Output decode; in_ready and sel_valid are pure decodes of the state flop
  always_comb begin
    in_ready_int  = 1'b0;
    sel_valid_int = 1'b0;
    case (state_q)
      LOAD: in_ready_int  = 1'b1;
      SCAN: sel_valid_int = 1'b1;
      default: in_ready_int = 1'b0;
    endcase
  end

  assign in_fire   = bus.in_valid & in_ready_int;
  assign sel_fire  = sel_valid_int & bus.sel_ready;
  assign last_word = (wr_cnt_q == SW'(S - 1));
  assign last_sel  = (sel_q == SW'(S - 1));

  // Datapath: words not rewritten keep the previous block's value
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      wr_cnt_q <= '0;
      sel_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= sel_fire & last_sel;
      if (in_fire) begin
        for (int k = 0; k < S; k++) begin
          if (wr_cnt_q == SW'(k)) a_q[k*N +: N] <= bus.in_data;
        end
        wr_cnt_q <= wr_cnt_q + SW'(1);
        if (last_word) sel_q <= '0;
      end
      if (sel_fire) sel_q <= sel_q + SW'(1);
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.sel_valid = sel_valid_int;
  assign bus.busy      = sel_valid_int;
  assign bus.a         = a_q;
  assign bus.sel       = sel_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_coeff_pack_buffer.sv
// Bench for coeff_pack_buffer: directed block scenarios plus randomized traffic,
// all checked against a word-array model of the load/scan behaviour.
module tb_coeff_pack_buffer;
  localparam int N  = 4;
  localparam int S  = 16;
  localparam int SW = $clog2(S);
  localparam int W  = S * N;

  logic clk;
  logic rst;

  coeff_pack_buffer_if #(.N(N), .S(S)) bus ();

  coeff_pack_buffer #(.N(N), .S(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;
  int edge_no;

  // Reference model: array of words plus a load/scan phase flag
  logic [N-1:0] m_words [S];
  bit           m_loading;
  int           m_count;
  int           m_sel;
  bit           m_done;

  // Scoreboard: expected packed vector for each completed load
  logic [W-1:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  function automatic logic [W-1:0] model_a();
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < S; k++) r[k*N +: N] = m_words[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < S; k++) m_words[k] = '0;
    m_loading = 1'b1;
    m_count   = 0;
    m_sel     = 0;
    m_done    = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic iv, input logic [N-1:0] id, input logic sr, input logic r);
    if (r) begin
      model_reset();
    end else begin
      m_done = 1'b0;
      if (m_loading) begin
        if (iv) begin
          m_words[m_count] = id;
          m_count++;
          if (m_count == S) begin
            m_loading = 1'b0;
            m_count   = 0;
            m_sel     = 0;
            exp_q.push_back(model_a());
          end
        end
      end else if (sr) begin
        if (m_sel == S - 1) begin
          m_done    = 1'b1;
          m_loading = 1'b1;
          m_sel     = 0;
        end else begin
          m_sel++;
        end
      end
    end
  endtask

  // Driver: called at a negedge; checks outputs, drives inputs, advances one edge
  task automatic drive_cycle(input logic iv, input logic [N-1:0] id, input logic sr, input logic r);
    logic [W-1:0] sb;
    check_eq("in_ready",  W'(bus.in_ready),  W'(m_loading));
    check_eq("sel_valid", W'(bus.sel_valid), W'(!m_loading));
    check_eq("busy",      W'(bus.busy),      W'(!m_loading));
    check_eq("state",     W'(bus.dbg_state), W'(!m_loading));
    check_eq("sel",       W'(bus.sel),       W'(m_sel));
    check_eq("a",         bus.a,             model_a());
    check_eq("done",      W'(bus.done),      W'(m_done));
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_done", W'(1), W'(0));
      end else begin
        sb = exp_q.pop_front();
        check_eq("sb_block_a", bus.a, sb);
      end
    end
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.sel_ready = sr;
    rst           = r;
    model_step(iv, id, sr, r);
    @(posedge clk);
    edge_no++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic scan_all();
    for (int i = 0; i < S; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    int e1;
    int e2;
    int dones;
    logic [SW-1:0] sel_seen;

    tests_run    = 0;
    tests_failed = 0;
    edge_no      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.sel_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state (checked inside drive_cycle), then load F..0 and scan
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < S; i++) drive_cycle(1'b1, N'(15 - i), 1'b1, 1'b0);
    check_eq("pack_f_to_0", bus.a, 64'h0123456789ABCDEF);
    scan_all();
    drive_cycle(1'b0, '0, 1'b0, 1'b0);

    // Input gaps: in_valid toggling
    for (int i = 0; i < 2 * S; i++) drive_cycle(1'(i % 2 == 0), N'(15 - i / 2), 1'b0, 1'b0);
    check_eq("pack_gaps", bus.a, 64'h0123456789ABCDEF);

    // Backpressure at sel=5, with in_valid/in_data=A held through the scan
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 4'hA, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 4'hA, 1'b0, 1'b0);
    sel_seen = bus.sel;
    check_eq("bp_hold_sel", W'(sel_seen), W'(5));
    for (int i = 0; i < S - 5; i++) drive_cycle(1'b1, 4'hA, 1'b1, 1'b0);
    drive_cycle(1'b1, 4'hA, 1'b1, 1'b0);
    check_eq("first_after_done_idx0", W'(bus.a[N-1:0]), W'(4'hA));

    // Reset after 7 words loaded
    do_reset();
    for (int i = 0; i < 7; i++) drive_cycle(1'b1, N'($urandom_range(0, 15)), 1'b1, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b1);
    check_eq("rst_load_a_zero", bus.a, '0);
    for (int i = 0; i < S; i++) drive_cycle(1'b1, 4'h3, 1'b1, 1'b0);
    check_eq("pack_all_3", bus.a, 64'h3333333333333333);
    scan_all();

    // Reset at sel=9 in SCAN
    for (int i = 0; i < S; i++) drive_cycle(1'b1, N'($urandom_range(0, 15)), 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("sel_at_9", W'(bus.sel), W'(9));
    drive_cycle(1'b0, '0, 1'b1, 1'b1);
    check_eq("rst_scan_a_zero", bus.a, '0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);

    // Back-to-back blocks: first accept to second done spans 4*S edges
    drive_cycle(1'b1, N'($urandom_range(0, 15)), 1'b1, 1'b0);
    e1 = edge_no;
    e2 = -1;
    dones = 0;
    for (int i = 0; i < 200 && e2 < 0; i++) begin
      if (bus.done === 1'b1) begin
        dones++;
        if (dones == 2) e2 = edge_no;
      end
      if (e2 < 0) drive_cycle(1'b1, N'($urandom_range(0, 15)), 1'b1, 1'b0);
    end
    if (e2 < 0) check_eq("b2b_timeout", W'(0), W'(1));
    else check_eq("b2b_period", W'(e2 - e1 + 1), W'(4 * S));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive_cycle(1'($urandom_range(0, 3) != 0), N'($urandom_range(0, 15)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 299) == 0));
    end
    drive_cycle(1'b0, '0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
